// File: rtl/sd_dma_wr.sv
// Write-direction SD DMA: streams one SRAM block onto the 4-bit SD bus with per-line CRC16,
// then collects the card's CRC status token and waits out busy on DAT0.
module sd_dma_wr #(
    parameter int unsigned BLOCK_BYTES  = 512,
    parameter int unsigned PREAMBLE     = 2,
    parameter int unsigned STAT_TIMEOUT = 16,
    parameter int unsigned BUSY_TIMEOUT = 1048575
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SD_DMA_EN,
    output logic       SD_DMA_STATUS,
    output logic       SD_DMA_NEXTADDR,
    input  logic [7:0] SD_DMA_SRAM_DATA,
    output logic [2:0] SD_DMA_RESULT,
    inout  wire        SD_CLK,
    input  logic [3:0] SD_DAT_IN,
    output logic [3:0] SD_DAT_OUT,
    output logic       SD_DAT_OE
);
    typedef enum logic [3:0] {
        StIdle, StPre, StStart, StData, StCrc, StEnd, StWaitStat, StStat, StBusy, StDone
    } state_e;

    localparam logic [10:0] PreLast  = 11'(PREAMBLE - 1);
    localparam logic [10:0] DataLast = 11'(2 * BLOCK_BYTES - 1);
    localparam logic [10:0] StatLast = 11'(STAT_TIMEOUT - 1);
    localparam logic [19:0] BusyLast = 20'(BUSY_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [19:0]       busy_cnt_q, busy_cnt_d;
    logic [2:0]        en_q;
    logic              pend_q, pend_d;
    logic [2:0]        stat_q, stat_d;
    logic [2:0]        result_q, result_d;
    logic              status_q, status_d;
    logic              sd_clk_q, sd_clk_d;
    logic              dat0_q;
    logic [7:0]        byte_q, byte_d;
    logic [3:0]        dat_q, dat_d;
    logic              oe_q, oe_d;
    logic              nextaddr_q, nextaddr_d;
    logic [3:0][15:0]  crc_q, crc_d;
    logic              rise, tick, step, active_q, active_d;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
        crc_upd = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    assign rise     = (en_q[2:1] == 2'b01);
    // A step boundary is the CLK edge on which SD_CLK falls (phase 3 -> 0).
    assign tick     = status_q && (phase_q == 2'd3);
    assign active_q = !(state_q inside {StIdle, StDone});
    assign active_d = !(state_d inside {StIdle, StDone});

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_cnt_d = busy_cnt_q;
        stat_d     = stat_q;
        result_d   = result_q;
        pend_d     = pend_q;
        unique case (state_q)
            StIdle: begin
                pend_d = 1'b0;
                if (rise || pend_q) begin
                    state_d  = StPre;
                    cnt_d    = '0;
                    result_d = 3'b000;
                end
            end
            StPre: if (tick) begin
                if (cnt_q == PreLast) begin state_d = StStart; cnt_d = '0; end
                else cnt_d = cnt_q + 11'd1;
            end
            StStart: if (tick) begin state_d = StData; cnt_d = '0; end
            StData: if (tick) begin
                if (cnt_q == DataLast) begin state_d = StCrc; cnt_d = '0; end
                else cnt_d = cnt_q + 11'd1;
            end
            StCrc: if (tick) begin
                if (cnt_q == 11'd15) begin state_d = StEnd; cnt_d = '0; end
                else cnt_d = cnt_q + 11'd1;
            end
            StEnd: if (tick) begin state_d = StWaitStat; cnt_d = '0; end
            StWaitStat: if (tick) begin
                if (!dat0_q) begin
                    state_d = StStat;
                    cnt_d   = '0;
                end else if (cnt_q == StatLast) begin
                    state_d  = StDone;
                    result_d = 3'b100;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            StStat: if (tick) begin
                if (cnt_q != 11'd3) begin
                    stat_d = {stat_q[1:0], dat0_q};
                    cnt_d  = cnt_q + 11'd1;
                end else if (dat0_q && stat_q == 3'b010) begin
                    state_d    = StBusy;
                    busy_cnt_d = '0;
                end else begin
                    state_d  = StDone;
                    result_d = (dat0_q && stat_q == 3'b101) ? 3'b001 : 3'b010;
                end
            end
            StBusy: if (tick) begin
                if (dat0_q) begin
                    state_d = StDone;
                end else if (busy_cnt_q == BusyLast) begin
                    state_d  = StDone;
                    result_d = 3'b011;
                end else begin
                    busy_cnt_d = busy_cnt_q + 20'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                // Keep a start that lands here so IDLE still takes it.
                if (rise) pend_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        step       = tick || (state_q == StIdle && state_d == StPre);
        phase_d    = (active_q && active_d) ? phase_q + 2'd1 : 2'd0;
        sd_clk_d   = active_d && phase_d[1];
        status_d   = (state_d != StIdle);
        nextaddr_d = (state_q == StData) && (phase_q == 2'd0) && !cnt_q[0];
        dat_d      = dat_q;
        oe_d       = oe_q;
        byte_d     = byte_q;
        crc_d      = crc_q;
        if (state_q == StIdle && state_d == StPre) crc_d = '0;
        if (step) begin
            oe_d  = 1'b1;
            dat_d = 4'hF;
            unique case (state_d)
                StPre, StEnd: dat_d = 4'hF;
                StStart:      dat_d = 4'h0;
                StData: begin
                    if (cnt_d[0]) begin
                        dat_d = byte_q[3:0];
                    end else begin
                        byte_d = SD_DMA_SRAM_DATA;
                        dat_d  = SD_DMA_SRAM_DATA[7:4];
                    end
                end
                StCrc: for (int i = 0; i < 4; i++) dat_d[i] = crc_q[i][4'd15 - cnt_d[3:0]];
                default: oe_d = 1'b0;
            endcase
            if (state_d == StData) begin
                for (int i = 0; i < 4; i++) crc_d[i] = crc_upd(crc_q[i], dat_d[i]);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            phase_q    <= '0;
            cnt_q      <= '0;
            busy_cnt_q <= '0;
            en_q       <= '0;
            pend_q     <= 1'b0;
            stat_q     <= '0;
            result_q   <= 3'b000;
            status_q   <= 1'b0;
            sd_clk_q   <= 1'b0;
            dat0_q     <= 1'b1;
            byte_q     <= '0;
            dat_q      <= 4'hF;
            oe_q       <= 1'b0;
            nextaddr_q <= 1'b0;
            crc_q      <= '0;
        end else begin
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            busy_cnt_q <= busy_cnt_d;
            en_q       <= {en_q[1:0], SD_DMA_EN};
            pend_q     <= pend_d;
            stat_q     <= stat_d;
            result_q   <= result_d;
            status_q   <= status_d;
            sd_clk_q   <= sd_clk_d;
            if (status_q && phase_q == 2'd2) dat0_q <= SD_DAT_IN[0];
            byte_q     <= byte_d;
            dat_q      <= dat_d;
            oe_q       <= oe_d;
            nextaddr_q <= nextaddr_d;
            crc_q      <= crc_d;
        end
    end

    assign SD_DMA_STATUS   = status_q;
    assign SD_DMA_NEXTADDR = nextaddr_q;
    assign SD_DMA_RESULT   = result_q;
    assign SD_DAT_OUT      = dat_q;
    assign SD_DAT_OE       = oe_q;
    assign SD_CLK          = status_q ? sd_clk_q : 1'bz;
endmodule

// File: doc/sd_dma_wr.md
Name: sd_dma_wr

Overview:
- Write-direction SD DMA engine: streams one data block from SRAM onto the 4-bit SD data bus in 4-bit wide-bus mode.
- Per frame: emits preamble, start nibble, data nibbles, per-line CRC16 and end nibble.
- Then samples the card's CRC status token and waits out card busy on DAT0.
- Sits beside the card-read DMA on the same SD_CLK/SD_DAT pins and the same SRAM address-increment scheme. The MCU issues the write command; this block moves only the data block.

Parameters:
- BLOCK_BYTES, 512, bytes per block; nibble count = 2*BLOCK_BYTES.
- PREAMBLE, 2, number of all-ones nibbles driven before the start nibble.
- STAT_TIMEOUT, 16, SD clocks allowed between end nibble and CRC-status start bit.
- BUSY_TIMEOUT, 1048575, SD clocks allowed for the card-busy phase (20-bit counter).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- SD_DMA_EN  in  1  start request; a rising edge starts a transfer
- SD_DMA_STATUS  out  1  high while a transfer is active
- SD_DMA_NEXTADDR  out  1  one-CLK pulse; SRAM address increment
- SD_DMA_SRAM_DATA  in  8  SRAM read data at current address
- SD_DMA_RESULT  out  3  completion code, held until next start
- SD_CLK  inout  1  SD clock; driven only while SD_DMA_STATUS is high, else Z
- SD_DAT_IN  in  4  SD data pins (input path)
- SD_DAT_OUT  out  4  SD data pins (output path)
- SD_DAT_OE  out  1  high = host drives SD_DAT

Behaviour:
- Reset (any time, including mid-transfer) returns all outputs immediately to idle:
  - state IDLE, SD_DMA_STATUS=0, SD_DMA_NEXTADDR=0
  - SD_DAT_OE=0, SD_DAT_OUT=4'hF, SD_CLK=Z
  - SD_DMA_RESULT=3'b000, all counters and CRCs 0
- Start detection: SD_DMA_EN passes through a 2-FF synchroniser; start occurs when the history equals 2'b01.
  - A rising edge while active is ignored.
  - Start clears SD_DMA_RESULT to 3'b000 and sets SD_DMA_STATUS the next CLK.
- SD clock generation: 2-bit phase counter, 4 CLK per SD_CLK.
  - SD_CLK is registered, low in phases 0-1 and high in phases 2-3.
  - SD_DAT_OUT and SD_DAT_OE update only on the phase-0 edge, so data changes on falling SD_CLK and is stable 2 CLK before the rise.
  - DAT0 is sampled on the phase-3 edge.
  - One "step" below = one SD clock.
- Data path:
  - High nibble goes first.
  - SD_DMA_SRAM_DATA is latched at the phase-0 edge that starts each byte's high nibble.
  - SD_DMA_NEXTADDR pulses 1 CLK at the following phase-1 edge. The next byte therefore has 7 CLK to settle.
  - Byte 0 is read from the pre-loaded address with no preceding pulse.
  - Exactly BLOCK_BYTES pulses occur per transfer; no pulse occurs outside DATA.
- CRC: four independent CRC16-CCITT generators (x^16+x^12+x^5+1, init 0), one per line.
  - Each is updated with its line's bit of every DATA nibble.
  - CRC nibble k (k=0..15) carries bit 15-k of each line's CRC, line i on bit i.
- FSM, one step per state unless counted:
  - IDLE: SD_CLK Z; on start -> PRE.
  - PRE: OE=1, DAT=F for PREAMBLE steps -> START.
  - START: DAT=0, 1 step -> DATA.
  - DATA: 2*BLOCK_BYTES steps (11-bit counter) -> CRC.
  - CRC: 16 steps -> END.
  - END: DAT=F, 1 step -> WAITSTAT.
  - WAITSTAT: OE=0; DAT0 sampled each step.
    - DAT0=0 -> STAT.
    - After STAT_TIMEOUT steps without it: RESULT=3'b100 -> DONE.
  - STAT: shift 3 status bits, then sample end bit.
    - 3'b010 -> BUSY.
    - 3'b101 -> RESULT=3'b001 -> DONE.
    - Any other code or end bit 0 -> RESULT=3'b010 -> DONE.
  - BUSY: clock runs; DAT0 high sampled -> DONE. After BUSY_TIMEOUT steps: RESULT=3'b011 -> DONE.
  - DONE: SD_DMA_STATUS=0 the next CLK, SD_CLK released to Z -> IDLE.
- Frame length, host-driven steps = PREAMBLE + 1 + 2*BLOCK_BYTES + 16 + 1 = 1044 at default parameters.
- SD_DAT_OE is never high in WAITSTAT, STAT or BUSY.
- A start event coinciding with the DONE-to-IDLE transition is taken on the following IDLE cycle, not lost.

Test Plan:
- Accepted write: BLOCK_BYTES=512, SRAM bytes all 0x00; card model returns token 0,010,1, then DAT0 low for 100 steps.
  - Expect 1044 driven steps: 2xF, one 0, 1024x0, 16x0 CRC nibbles, one F.
  - Expect exactly 512 NEXTADDR pulses.
  - Expect RESULT=000 and STATUS low after busy release.
- Incrementing data: byte n = n[7:0].
  - DAT nibbles 0,0,0,1,0,2,...,F,F repeating.
  - Per-line CRC nibbles match the bench CRC16 model.
  - Every byte is latched 7 CLK after its NEXTADDR pulse.
- CRC-error token 0,101,1 -> RESULT=001, no BUSY phase. Token 0,110,1 -> RESULT=010.
- No token: DAT0 held high -> RESULT=100 after 16 steps. Token then DAT0 held low with BUSY_TIMEOUT=1000 -> RESULT=011 at step 1000.
- RST_N asserted low at data nibble 300:
  - Outputs go to idle values asynchronously (OE=0, SD_CLK Z, STATUS=0, no further NEXTADDR).
  - A new SD_DMA_EN rising edge after release starts a clean frame beginning with PREAMBLE.
- SD_DMA_EN toggled during DATA -> ignored: frame unchanged, still 512 pulses.
